// File: rtl/dice_roll_ctrl.sv
// Dice roll controller: animates a reduced random value on a BCD display, then latches the result.
// Optional advantage mode (best of two captures) is built when DICE_ADV_EN is defined.
module dice_roll_ctrl #(
  parameter int TICK_DIV    = 4,
  parameter int ANIM_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       roll_req,
  input  logic [4:0] rand_in,
  input  logic [2:0] die_sel,
`ifdef DICE_ADV_EN
  input  logic       adv_sel,
`endif
  output logic       busy,
  output logic [4:0] result,
  output logic       result_valid,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       crit_hit,
  output logic       crit_miss
);

`ifdef DICE_ADV_EN
  typedef enum logic [2:0] {IDLE, ANIM, CAPTURE, DONE, ADV} state_t;
`else
  typedef enum logic [2:0] {IDLE, ANIM, CAPTURE, DONE} state_t;
`endif

  state_t     state;
  logic [7:0] tick, upd;
  logic       roll_q, armed;
  logic [2:0] die_q;
  logic [4:0] red, fin;
  logic       roll_edge, tick_end;

  // clamp to 1..20, then fold onto 1..N
  function automatic logic [4:0] reduce(input logic [4:0] r, input logic [2:0] die);
    logic [4:0] m;
    m = (r == 5'd0) ? 5'd0 : (r > 5'd20) ? 5'd19 : r - 5'd1;
    case (die)
      3'd0:    reduce = (m % 5'd4)  + 5'd1;
      3'd1:    reduce = (m % 5'd6)  + 5'd1;
      3'd2:    reduce = (m % 5'd8)  + 5'd1;
      3'd3:    reduce = (m % 5'd10) + 5'd1;
      3'd4:    reduce = (m % 5'd12) + 5'd1;
      default: reduce = m + 5'd1;
    endcase
  endfunction

  function automatic logic [7:0] to_bcd(input logic [4:0] v);
    if (v >= 5'd20)      to_bcd = {4'd2, 4'(v - 5'd20)};
    else if (v >= 5'd10) to_bcd = {4'd1, 4'(v - 5'd10)};
    else                 to_bcd = {4'd0, v[3:0]};
  endfunction

  // armed blocks a held-high roll_req from looking like an edge right after reset
  assign roll_edge = roll_req & ~roll_q & armed;
  assign tick_end  = (tick == 8'(TICK_DIV - 1));
  assign red       = reduce(rand_in, die_q);

`ifdef DICE_ADV_EN
  logic       adv_q;
  logic [4:0] cap1;
  assign fin = (state == ADV && cap1 > red) ? cap1 : red;
`else
  assign fin = red;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      tick         <= '0;
      upd          <= '0;
      roll_q       <= 1'b0;
      armed        <= 1'b0;
      die_q        <= '0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      tens         <= '0;
      ones         <= '0;
      crit_hit     <= 1'b0;
      crit_miss    <= 1'b0;
`ifdef DICE_ADV_EN
      adv_q        <= 1'b0;
      cap1         <= '0;
`endif
    end else begin
      roll_q       <= roll_req;
      armed        <= armed | ~roll_req;
      result_valid <= 1'b0;
      case (state)
        IDLE: if (roll_edge) begin
          die_q <= die_sel;
`ifdef DICE_ADV_EN
          adv_q <= adv_sel;
`endif
          busy  <= 1'b1;
          tick  <= '0;
          upd   <= '0;
          state <= (ANIM_CYCLES == 1) ? CAPTURE : ANIM;
        end
        ANIM: if (tick_end) begin
          tick          <= '0;
          {tens, ones}  <= to_bcd(red);
          upd           <= upd + 8'd1;
          if (upd == 8'(ANIM_CYCLES - 2)) state <= CAPTURE;
        end else tick <= tick + 8'd1;
        DONE: state <= IDLE;
        default: if (tick_end) begin
          tick <= '0;
`ifdef DICE_ADV_EN
          if (state == CAPTURE && adv_q) begin
            cap1         <= red;
            {tens, ones} <= to_bcd(red);
            state        <= ADV;
          end else begin
`else
          begin
`endif
            result       <= fin;
            {tens, ones} <= to_bcd(fin);
            crit_hit     <= (die_q >= 3'd5) && (fin == 5'd20);
            crit_miss    <= (die_q >= 3'd5) && (fin == 5'd1);
            result_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= DONE;
          end
        end else tick <= tick + 8'd1;
      endcase
    end
  end

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Directed bench for dice_roll_ctrl with TICK_DIV=2, ANIM_CYCLES=4 (latency 9 clocks, +2 in advantage mode).
module tb_dice_roll_ctrl;
  localparam int TD = 2, AC = 4;

  logic       clk = 1'b0, reset = 1'b1, roll_req = 1'b0;
  logic [4:0] rand_in = '0;
  logic [2:0] die_sel = '0;
  logic       busy, result_valid, crit_hit, crit_miss;
  logic [4:0] result;
  logic [3:0] tens, ones;
`ifdef DICE_ADV_EN
  logic       adv_sel = 1'b0;
`endif

  int cyc = 0, n_chk = 0, n_err = 0;

  dice_roll_ctrl #(.TICK_DIV(TD), .ANIM_CYCLES(AC)) dut (
    .clk(clk), .reset(reset), .roll_req(roll_req), .rand_in(rand_in), .die_sel(die_sel),
`ifdef DICE_ADV_EN
    .adv_sel(adv_sel),
`endif
    .busy(busy), .result(result), .result_valid(result_valid), .tens(tens), .ones(ones),
    .crit_hit(crit_hit), .crit_miss(crit_miss)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one roll: edge in cycle t, die_sel flipped right after the edge, rand_in switches to r2 at t+9,
  // optional second roll_req edge at t+reoff
  task automatic roll(input string tag, input logic [2:0] die, input logic [4:0] r, input logic [4:0] r2,
                      input logic adv, input int reoff, input int exp_lat,
                      input int exp_res, input int exp_hit, input int exp_miss);
    int t, nv, nb, vat;
    die_sel = die;
    rand_in = r;
`ifdef DICE_ADV_EN
    adv_sel = adv;
`endif
    @(posedge clk); #1;
    roll_req = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    roll_req = 1'b0;
    die_sel  = ~die;
`ifdef DICE_ADV_EN
    adv_sel  = ~adv;
`endif
    nv = 0; nb = 0; vat = -1;
    for (int i = 1; i <= 20; i++) begin
      roll_req = (reoff > 0 && i == reoff);
      if (i == 9) rand_in = r2;
      @(negedge clk);
      if (busy) nb++;
      if (result_valid) begin
        nv++;
        if (vat < 0) vat = cyc - t;
      end
      @(posedge clk); #1;
    end
    roll_req = 1'b0;
    chk({tag, " latency"}, vat, exp_lat);
    chk({tag, " valid_pulses"}, nv, 1);
    chk({tag, " busy_cycles"}, nb, exp_lat - 1);
    chk({tag, " result"}, int'(result), exp_res);
    chk({tag, " bcd"}, int'(tens) * 10 + int'(ones), exp_res);
    chk({tag, " crit_hit"}, int'(crit_hit), exp_hit);
    chk({tag, " crit_miss"}, int'(crit_miss), exp_miss);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " result"}, int'(result), 0);
    chk({tag, " valid"}, int'(result_valid), 0);
    chk({tag, " tens"}, int'(tens), 0);
    chk({tag, " ones"}, int'(ones), 0);
    chk({tag, " crit"}, int'({crit_hit, crit_miss}), 0);
  endtask

  initial begin
    int nv, nb;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("por");
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    roll("d6_13",   3'd1, 5'd13, 5'd13, 1'b0, 0, 9, 1, 0, 0);
    chk("d6 tens", int'(tens), 0);
    chk("d6 ones", int'(ones), 1);
    roll("d20_20",  3'd7, 5'd20, 5'd20, 1'b0, 0, 9, 20, 1, 0);
    chk("d20 tens", int'(tens), 2);
    chk("d20 ones", int'(ones), 0);
    roll("d4_7",    3'd0, 5'd7,  5'd7,  1'b0, 0, 9, 3, 0, 0);
    roll("reedge",  3'd1, 5'd13, 5'd13, 1'b0, 4, 9, 1, 0, 0);
    roll("d8_0",    3'd2, 5'd0,  5'd0,  1'b0, 0, 9, 1, 0, 0);
    roll("d20_31",  3'd5, 5'd31, 5'd31, 1'b0, 0, 9, 20, 1, 0);
    roll("d10_15",  3'd3, 5'd15, 5'd15, 1'b0, 0, 9, 5, 0, 0);
    roll("d12_19",  3'd4, 5'd19, 5'd19, 1'b0, 0, 9, 7, 0, 0);
    roll("d12_20",  3'd4, 5'd20, 5'd20, 1'b0, 0, 9, 8, 0, 0);
    roll("d20_1",   3'd6, 5'd1,  5'd1,  1'b0, 0, 9, 1, 0, 1);

    // reset mid-animation with roll_req held high through release
    die_sel = 3'd7; rand_in = 5'd20;
    @(posedge clk); #1; roll_req = 1'b1;
    repeat (4) @(posedge clk);
    #1; reset = 1'b1;
    #1; chk_reset_vals("midreset");
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    nv = 0; nb = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (result_valid) nv++;
    end
    chk("midreset valid_pulses", nv, 0);
    chk("midreset held_req busy", nb, 0);
    chk("midreset result", int'(result), 0);
    @(posedge clk); #1; roll_req = 1'b0;
    roll("post_reset", 3'd1, 5'd13, 5'd13, 1'b0, 0, 9, 1, 0, 0);

`ifdef DICE_ADV_EN
    roll("adv_5_17",  3'd7, 5'd5,  5'd17, 1'b1, 0, 11, 17, 0, 0);
    roll("adv_18_3",  3'd7, 5'd18, 5'd3,  1'b1, 0, 11, 18, 0, 0);
    roll("adv_1_20",  3'd7, 5'd1,  5'd20, 1'b1, 0, 11, 20, 1, 0);
    roll("adv_off",   3'd7, 5'd5,  5'd17, 1'b0, 0, 9, 5, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/dice_roll_ctrl.md
DICE_ROLL_CTRL -- requirements
Module: dice_roll_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 4, clocks per animation update (legal range 1..255).
REQ-002 Parameter ANIM_CYCLES, default 16, number of animation updates per roll (legal range 1..255).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 roll_req  input  1  roll request; a rising edge starts a roll.
REQ-006 rand_in  input  5  free-running random value from the upstream random source, nominally 1..20.
REQ-007 die_sel  input  3  die type: 0=d4, 1=d6, 2=d8, 3=d10, 4=d12, 5..7=d20.
REQ-008 busy  output  1  high while a roll is in progress.
REQ-009 result  output  5  final roll value, held until the next roll completes.
REQ-010 result_valid  output  1  one-cycle pulse when result updates.
REQ-011 tens  output  4  BCD tens digit of the displayed value.
REQ-012 ones  output  4  BCD ones digit of the displayed value.
REQ-013 crit_hit  output  1  high when the latched die is d20 and result=20; held with result.
REQ-014 crit_miss  output  1  high when the latched die is d20 and result=1; held with result.
REQ-015 adv_sel  input  1  advantage-mode select; port exists only when DICE_ADV_EN is defined.

Function
REQ-016 Clamp rand_in before reduction: 0 becomes 1; 21..31 become 20.
REQ-017 Reduce the clamped value r for die size N as ((r-1) mod N)+1, giving a value in 1..N.
REQ-018 Detect a roll_req rising edge from roll_req at cycle t and a registered copy from cycle t-1.
REQ-019 The FSM has states IDLE, ANIM, CAPTURE and DONE, plus ADV when DICE_ADV_EN is defined.
REQ-020 IDLE to ANIM on a detected edge; die_sel, and adv_sel when present, are latched on the same edge.
REQ-021 busy is high from the cycle after the edge until the end of the roll.
REQ-022 In ANIM, the display value takes the reduced rand_in every TICK_DIV clocks, for ANIM_CYCLES updates; the final update is the capture.
REQ-023 At capture, result and the crit flags are loaded and the state goes to DONE.
REQ-024 DONE lasts one cycle: result_valid=1 and busy=0 in that cycle, then the state returns to IDLE.
REQ-025 Latency: an edge at cycle t gives result_valid in cycle t+1+ANIM_CYCLES*TICK_DIV.
REQ-026 Rising edges of roll_req while busy=1 or in DONE are ignored and are not queued.
REQ-027 tens and ones are the BCD of the display value; after a roll the display value equals result.
REQ-028 Changes to die_sel or adv_sel mid-roll have no effect on the roll in progress.

Reset
REQ-029 Reset returns the FSM to IDLE and clears the tick counter, update counter and edge register.
REQ-030 Reset values: busy=0, result=0, result_valid=0, tens=0, ones=0, crit_hit=0, crit_miss=0.
REQ-031 Reset mid-roll aborts the roll without a result_valid pulse; the next roll starts only on a fresh rising edge of roll_req after reset is released.

Configuration
REQ-032 Macro DICE_ADV_EN defined: when the latched adv_sel=1, the first capture is stored and the ADV state waits TICK_DIV clocks for a second capture.
REQ-033 With DICE_ADV_EN defined and adv_sel=1, result is the maximum of the two captures; latency increases by TICK_DIV; crit flags are evaluated on the maximum.
REQ-034 Macro DICE_ADV_EN not defined: the adv_sel port, the ADV state and the second-capture register are absent, and behaviour is the single-capture roll of REQ-022..REQ-025.

Verification
REQ-035 With TICK_DIV=2 and ANIM_CYCLES=4: d6, rand_in held 13, edge at cycle 10 -> result_valid at cycle 19, result=1, busy high cycles 11..18.
REQ-036 d20, rand_in held 20 -> result=20, tens=2, ones=0, crit_hit=1, crit_miss=0; d4, rand_in 7 -> result=3, both crit flags 0.
REQ-037 Second roll_req edge at cycle 14 during a roll -> ignored; exactly one result_valid pulse; rand_in 0 -> result=1; rand_in 31 on d20 -> result=20.
REQ-038 Reset asserted mid-ANIM -> all outputs at reset values; no result_valid pulse; a new edge after release -> normal roll.
REQ-039 DICE_ADV_EN defined, adv_sel=1, d20, rand_in 5 at the first capture then 17 at the second -> result=17 with latency 1+ANIM_CYCLES*TICK_DIV+TICK_DIV.
